sat_sub_16bit_seq: RTL and testbench

- Multi-cycle saturating subtractor; computes Diff = A - B as A + ~B + 1.
- Processes one 4-bit slice per cycle, LSB first, with the inter-slice carry held in a register.
- Clamps signed overflow to 0x7FFF / 0x8000 and produces N/Z/V flags.
- Serves as the area-lean SUB path of the ALU, behind a valid/ready handshake, so the execute stage can stall on it.

---
 rtl/sat_sub_16bit_seq_if.sv | 38 +++
 rtl/sat_sub_16bit_seq.sv | 143 ++++++++++++++
 tb/tb_sat_sub_16bit_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sat_sub_16bit_seq_if.sv
// Operand/result handshake bundle for sat_sub_16bit_seq.
// sat_en exists only when SAT_SUB_WRAP_MODE_EN is defined.
interface sat_sub_16bit_seq_if #(
   parameter int WIDTH = 16
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] Diff;
   logic             Cout;
   logic             N;
   logic             Z;
   logic             V;
`ifdef SAT_SUB_WRAP_MODE_EN
   logic             sat_en;

   modport master (
      output start_valid, A, B, res_ready, sat_en,
      input  start_ready, res_valid, Diff, Cout, N, Z, V
   );
   modport slave (
      input  start_valid, A, B, res_ready, sat_en,
      output start_ready, res_valid, Diff, Cout, N, Z, V
   );
`else
   modport master (
      output start_valid, A, B, res_ready,
      input  start_ready, res_valid, Diff, Cout, N, Z, V
   );
   modport slave (
      input  start_valid, A, B, res_ready,
      output start_ready, res_valid, Diff, Cout, N, Z, V
   );
`endif
endinterface

// File: rtl/sat_sub_16bit_seq.sv
// Slice-serial saturating subtractor, A + ~B + 1, one SLICE_W slice per cycle.
// Define SAT_SUB_WRAP_MODE_EN to add the sat_en wrap-around select.
module sat_sub_16bit_seq #(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   sat_sub_16bit_seq_if.slave bus
);
   localparam int NS = WIDTH / SLICE_W;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NS - 1);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] nb_q, nb_d;
   logic [WIDTH-1:0] raw_q, raw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             cout_q, cout_d;
   logic             n_q, n_d;
   logic             z_q, z_d;
   logic             v_q, v_d;
   logic             sat_use;
   logic             ovf;
   logic [SLICE_W:0] sum;
   int               idx;

`ifdef SAT_SUB_WRAP_MODE_EN
   logic sat_q, sat_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      nb_d    = nb_q;
      raw_d   = raw_q;
      diff_d  = diff_q;
      cout_d  = cout_q;
      n_d     = n_q;
      z_d     = z_q;
      v_d     = v_q;
      ovf     = 1'b0;
      sum     = '0;
      idx     = int'(cnt_q) * SLICE_W;
`ifdef SAT_SUB_WRAP_MODE_EN
      sat_d   = sat_q;
      sat_use = sat_q;
`else
      sat_use = 1'b1;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               a_d     = bus.A;
               nb_d    = ~bus.B;
               carry_d = 1'b1;
               cnt_d   = '0;
`ifdef SAT_SUB_WRAP_MODE_EN
               sat_d   = bus.sat_en;
`endif
               state_d = BUSY;
            end
         end
         BUSY: begin
            sum = {1'b0, a_q[idx +: SLICE_W]}
                + {1'b0, nb_q[idx +: SLICE_W]}
                + {{SLICE_W{1'b0}}, carry_q};
            raw_d[idx +: SLICE_W] = sum[SLICE_W-1:0];
            carry_d = sum[SLICE_W];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // operand signs differ iff a_msb equals inverted b_msb
               ovf = (a_q[WIDTH-1] == nb_q[WIDTH-1])
                   & (raw_d[WIDTH-1] != a_q[WIDTH-1]);
               cout_d = sum[SLICE_W];
               v_d    = ovf;
               if (ovf & sat_use)
                  diff_d = a_q[WIDTH-1] ? MIN_NEG : MAX_POS;
               else
                  diff_d = raw_d;
               n_d     = diff_d[WIDTH-1];
               z_d     = (diff_d == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         nb_q    <= '0;
         raw_q   <= '0;
         diff_q  <= '0;
         cout_q  <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         v_q     <= 1'b0;
`ifdef SAT_SUB_WRAP_MODE_EN
         sat_q   <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         nb_q    <= nb_d;
         raw_q   <= raw_d;
         diff_q  <= diff_d;
         cout_q  <= cout_d;
         n_q     <= n_d;
         z_q     <= z_d;
         v_q     <= v_d;
`ifdef SAT_SUB_WRAP_MODE_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign bus.start_ready = (state_q == IDLE);
   assign bus.res_valid   = (state_q == DONE);
   assign bus.Diff        = diff_q;
   assign bus.Cout        = cout_q;
   assign bus.N           = n_q;
   assign bus.Z           = z_q;
   assign bus.V           = v_q;
endmodule

// File: tb/tb_sat_sub_16bit_seq.sv
// Self-checking bench for sat_sub_16bit_seq: directed corners plus random
// operands against an integer-arithmetic reference model.
module tb_sat_sub_16bit_seq;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   sat_sub_16bit_seq_if #(.WIDTH(16)) bus ();

   sat_sub_16bit_seq #(.WIDTH(16), .SLICE_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer difference, clamp if outside 16-bit signed range
   task automatic model(input logic [15:0] a, input logic [15:0] b,
                        input logic sat, output logic [15:0] d,
                        output logic c, output logic n, output logic z,
                        output logic v);
      int sa, sb, ex;
      sa = $signed(a);
      sb = $signed(b);
      ex = sa - sb;
      v  = (ex > 32767) || (ex < -32768);
      c  = (a >= b);
      if (v && sat) d = (ex > 0) ? 16'h7FFF : 16'h8000;
      else          d = a - b;
      n  = d[15];
      z  = (d == 16'h0000);
   endtask

   task automatic set_sat(input logic s);
`ifdef SAT_SUB_WRAP_MODE_EN
      bus.sat_en = s;
`else
      if (s) ;
`endif
   endtask

   task automatic chk_result(input string tag, input logic [15:0] d,
                             input logic c, input logic n, input logic z,
                             input logic v);
      check({tag, ".diff"}, {16'h0, bus.Diff}, {16'h0, d});
      check({tag, ".flags"}, {27'h0, bus.res_valid, bus.Cout, bus.N, bus.Z, bus.V},
            {27'h0, 1'b1, c, n, z, v});
      check({tag, ".sready"}, {31'h0, bus.start_ready}, 32'h0);
   endtask

   // Presents one op, checks 4-cycle latency, holds res_ready low for hold cycles
   task automatic do_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic s, input int hold);
      logic [15:0] d;
      logic c, n, z, v;
      bit ok;
      model(a, b, s, d, c, n, z, v);
      bus.A = a;
      bus.B = b;
      set_sat(s);
      bus.start_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.start_ready) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      check({tag, ".accept"}, {31'h0, ok}, 32'h1);
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      set_sat(~s);
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".early"}, {31'h0, bus.res_valid}, 32'h0);
      @(posedge clk); #1;
      chk_result(tag, d, c, n, z, v);
      for (int i = 0; i < hold; i++) begin
         bus.A = 16'($urandom);
         bus.B = 16'($urandom);
         bus.start_valid = ~bus.start_valid;
         @(posedge clk); #1;
         chk_result({tag, ".hold"}, d, c, n, z, v);
      end
      bus.start_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      check({tag, ".drop"}, {30'h0, bus.res_valid, bus.start_ready}, 32'h1);
   endtask

   initial begin
      logic [15:0] ra, rb;
      n_chk = 0;
      n_fail = 0;
      bus.start_valid = 1'b0;
      bus.res_ready = 1'b0;
      bus.A = '0;
      bus.B = '0;
      set_sat(1'b1);
      rst_n = 1'b0;
      #12;
      check("reset.out", {bus.Diff, 11'h0, bus.Cout, bus.N, bus.Z, bus.V, bus.res_valid},
            32'h0);
      check("reset.sready", {31'h0, bus.start_ready}, 32'h1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("release.sready", {30'h0, bus.start_ready, bus.res_valid}, 32'h2);

      do_op("basic", 16'h0005, 16'h0003, 1'b1, 0);
      do_op("satpos", 16'h7FFF, 16'hFFFF, 1'b1, 0);
      do_op("satneg", 16'h8000, 16'h0001, 1'b1, 0);
      do_op("zero", 16'h1234, 16'h1234, 1'b1, 0);
      do_op("borrow", 16'h0000, 16'h0001, 1'b1, 0);
      do_op("minmax", 16'h8000, 16'h7FFF, 1'b1, 0);

      // Start held through DONE must not be taken until after the handshake
      do_op("bp", 16'h4000, 16'hC000, 1'b1, 3);
      bus.start_valid = 1'b1;
      bus.res_ready = 1'b0;
      do_op("bp.next", 16'h0100, 16'h0001, 1'b1, 0);

      // Async reset during the second BUSY cycle
      bus.A = 16'h00F0;
      bus.B = 16'h0001;
      bus.start_valid = 1'b1;
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst.out", {bus.Diff, 11'h0, bus.Cout, bus.N, bus.Z, bus.V, bus.res_valid},
            32'h0);
      check("midrst.sready", {31'h0, bus.start_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("midrst.nopulse", {30'h0, bus.res_valid, bus.start_ready}, 32'h1);
      do_op("postrst", 16'h0010, 16'h0001, 1'b1, 0);

`ifdef SAT_SUB_WRAP_MODE_EN
      do_op("wrap", 16'h7FFF, 16'hFFFF, 1'b0, 0);
      do_op("wrap.neg", 16'h8000, 16'h0001, 1'b0, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 4 == 0) rb = {~ra[15], rb[14:0]};
         do_op("rand", ra, rb, 1'b1, int'($urandom_range(0, 2)));
`ifdef SAT_SUB_WRAP_MODE_EN
         do_op("rand.wrap", ra, rb, 1'b0, 0);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
